// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed driver for a multi-digit seven-segment display. Each digit
// carries one hex nibble, a decimal point and a blank flag. The digits are
// scanned round-robin. Every digit slot begins with a dead interval in which
// all anodes are off, so the previous digit cannot ghost into the next one.
// Host writes land in a pending buffer. They are promoted to the displayed
// (active) buffer only at a frame boundary, so a frame never shows a mix of
// old and new digits.
//
// Build option:
//   LEADING_ZERO_SUPPRESS_EN - when defined, a digit is also blanked when its
//                              own nibble and every higher nibble are zero.
//                              Digit 0 is never suppressed. The decimal point
//                              of a suppressed digit still lights.
//
// Parameters:
//   NUM_DIGITS      digits scanned (1..8)
//   DIGIT_CYCLES    clock cycles per digit slot (>= 2)
//   DEAD_CYCLES     leading cycles of each slot with all anodes off
//   SEG_ACTIVE_LOW  1 = o_segs/o_dp driven low to light a segment
//   AN_ACTIVE_LOW   1 = o_an driven low to select a digit
//
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_load          single-cycle strobe; captures i_data/i_dp/i_blank
//   i_data          hex nibbles, digit k = [4k+3:4k], digit 0 rightmost
//   i_dp            decimal point enable per digit
//   i_blank         blank enable per digit
//   o_segs          segments {a,b,c,d,e,f,g}, bit 6 = a
//   o_dp            decimal point of the selected digit
//   o_an            digit select, one-hot when active
//   o_pending       captured data is waiting for the next frame boundary
//   o_frame_start   one-cycle pulse after each frame boundary
//
// All outputs are registered and reflect the state one cycle earlier.
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
   parameter int NUM_DIGITS     = 4,
   parameter int DIGIT_CYCLES   = 50000,
   parameter int DEAD_CYCLES    = 500,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_load,
   input  logic [4*NUM_DIGITS-1:0] i_data,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic [NUM_DIGITS-1:0]   i_blank,
   output logic [6:0]              o_segs,
   output logic                    o_dp,
   output logic [NUM_DIGITS-1:0]   o_an,
   output logic                    o_pending,
   output logic                    o_frame_start
);

   // ---------------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------------
   localparam int PW = $clog2(DIGIT_CYCLES);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_CYCLES - 1);
   localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYCLES);
   localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);

   // "Off" levels for each output group. XOR-ing an active-high value with
   // the off level gives the pin level for either polarity.
   localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ?
                                               {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   // ---------------------------------------------------------------------------
   // Hex to segment glyph, active-high, bit 6 = a ... bit 0 = g
   // ---------------------------------------------------------------------------
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      g = 7'h00;
      unique case (nib)
         4'h0: g = 7'h7E;
         4'h1: g = 7'h30;
         4'h2: g = 7'h6D;
         4'h3: g = 7'h79;
         4'h4: g = 7'h33;
         4'h5: g = 7'h5B;
         4'h6: g = 7'h5F;
         4'h7: g = 7'h70;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h7B;
         4'hA: g = 7'h77;
         4'hB: g = 7'h1F;
         4'hC: g = 7'h4E;
         4'hD: g = 7'h3D;
         4'hE: g = 7'h4F;
         4'hF: g = 7'h47;
      endcase
      return g;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [PW-1:0]           presc_q,      presc_d;
   logic [IW-1:0]           digit_q,      digit_d;

   logic [4*NUM_DIGITS-1:0] act_data_q,   act_data_d;
   logic [NUM_DIGITS-1:0]   act_dp_q,     act_dp_d;
   logic [NUM_DIGITS-1:0]   act_blank_q,  act_blank_d;

   logic [4*NUM_DIGITS-1:0] pend_data_q,  pend_data_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q,    pend_dp_d;
   logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic                    pending_q,    pending_d;

   logic [6:0]              segs_q,       segs_d;
   logic                    dp_q,         dp_d;
   logic [NUM_DIGITS-1:0]   an_q,         an_d;
   logic                    frame_start_q, frame_start_d;

   logic                    presc_wrap;
   logic                    frame_boundary;

   // ---------------------------------------------------------------------------
   // Scan timing: prescaler inside a slot, digit index across slots
   // ---------------------------------------------------------------------------
   assign presc_wrap     = (presc_q == PRESC_LAST);
   assign frame_boundary = presc_wrap && (digit_q == DIGIT_LAST);

   always_comb begin : scan_next
      // NOTE: every signal assigned in a combinational block gets a default
      // first; a path that leaves one unassigned would infer a latch.
      presc_d = presc_q + 1'b1;
      digit_d = digit_q;
      if (presc_wrap) begin
         presc_d = '0;
         digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Double buffer. A load on the boundary cycle bypasses the pending buffer,
   // so the newest data wins over anything already waiting.
   // ---------------------------------------------------------------------------
   always_comb begin : buffer_next
      act_data_d   = act_data_q;
      act_dp_d     = act_dp_q;
      act_blank_d  = act_blank_q;
      pend_data_d  = pend_data_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      pending_d    = pending_q;

      if (i_load && frame_boundary) begin
         act_data_d  = i_data;
         act_dp_d    = i_dp;
         act_blank_d = i_blank;
         pending_d   = 1'b0;
      end else if (i_load) begin
         pend_data_d  = i_data;
         pend_dp_d    = i_dp;
         pend_blank_d = i_blank;
         pending_d    = 1'b1;
      end else if (frame_boundary && pending_q) begin
         act_data_d  = pend_data_q;
         act_dp_d    = pend_dp_q;
         act_blank_d = pend_blank_q;
         pending_d   = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Leading-zero suppression mask (bit k set = digit k suppressed)
   // ---------------------------------------------------------------------------
   logic [NUM_DIGITS-1:0] lz_blank;

`ifdef LEADING_ZERO_SUPPRESS_EN
   always_comb begin : lz_mask
      logic zero_above;
      lz_blank   = '0;
      zero_above = 1'b1;
      // Walk from the most significant digit down; stop short of digit 0 so
      // an all-zero value still shows a single "0".
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_above  = zero_above && (act_data_q[4*k +: 4] == 4'h0);
         lz_blank[k] = zero_above;
      end
   end
`else
   assign lz_blank = '0;
`endif

   // ---------------------------------------------------------------------------
   // Per-digit selection (explicit compare loop keeps every index in range
   // for digit counts that are not a power of two)
   // ---------------------------------------------------------------------------
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_blank;
   logic                  cur_lz;
   logic [NUM_DIGITS-1:0] cur_onehot;

   always_comb begin : digit_select
      cur_nib    = 4'h0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      cur_lz     = 1'b0;
      cur_onehot = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (digit_q == IW'(k)) begin
            cur_nib       = act_data_q[4*k +: 4];
            cur_dp        = act_dp_q[k];
            cur_blank     = act_blank_q[k];
            cur_lz        = lz_blank[k];
            cur_onehot[k] = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output next-state. Everything is dark during the dead interval and for
   // an explicitly blanked digit. A suppressed leading zero keeps its anode
   // only when its decimal point has to be shown.
   // ---------------------------------------------------------------------------
   logic in_dead;
   assign in_dead = (presc_q < DEAD_END);

   always_comb begin : output_next
      an_d          = AN_OFF;
      segs_d        = SEG_OFF;
      dp_d          = DP_OFF;
      frame_start_d = frame_boundary;

      if (!in_dead && !cur_blank) begin
         if (!cur_lz) begin
            an_d   = cur_onehot ^ AN_OFF;
            segs_d = hex_glyph(cur_nib) ^ SEG_OFF;
            dp_d   = cur_dp ^ DP_OFF;
         end else if (cur_dp) begin
            an_d = cur_onehot ^ AN_OFF;
            dp_d = ~DP_OFF;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         presc_q       <= '0;
         digit_q       <= '0;
         // NOTE: the digit buffers are small flop banks, not RAM. They are
         // reset so the display shows zeros and any pending write is dropped.
         act_data_q    <= '0;
         act_dp_q      <= '0;
         act_blank_q   <= '0;
         pend_data_q   <= '0;
         pend_dp_q     <= '0;
         pend_blank_q  <= '0;
         pending_q     <= 1'b0;
         segs_q        <= SEG_OFF;
         dp_q          <= DP_OFF;
         an_q          <= AN_OFF;
         frame_start_q <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         digit_q       <= digit_d;
         act_data_q    <= act_data_d;
         act_dp_q      <= act_dp_d;
         act_blank_q   <= act_blank_d;
         pend_data_q   <= pend_data_d;
         pend_dp_q     <= pend_dp_d;
         pend_blank_q  <= pend_blank_d;
         pending_q     <= pending_d;
         segs_q        <= segs_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign o_segs        = segs_q;
   assign o_dp          = dp_q;
   assign o_an          = an_q;
   assign o_pending     = pending_q;
   assign o_frame_start = frame_start_q;

endmodule
